fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Sequences the combinational 18-bit instruction memory for the pipeline front end.
//  - Owns the PC and drives the byte address; memory indexes by word (addr[17:2]).
//  - Captures each returned instruction with its PC into a small prefetch queue.
//  - Hands the queue head to decode with a valid/ready handshake.
//  - On a branch redirect: flushes the queue and refetches from the new target.
//  - Stops fetching at the end of the populated program space.
// PARAMETERS
//  ADDR_W    18   byte-address / PC width
//  INSTR_W   18   instruction width
//  DEPTH     2    prefetch queue entries (power of 2, >=2)
//  RESET_PC  0    PC loaded on reset
//  END_PC    404  first byte address NOT fetched (101 words x 4)
// PORTS
//  clk             in   1        clock, rising edge
//  reset           in   1        asynchronous, active-high reset
//  fetch_en        in   1        1 = fetching allowed; 0 = hold PC, no push (pop still allowed)
//  imem_addr       out  ADDR_W   byte address to instruction memory, = pc register
//  imem_rd         in   INSTR_W  instruction word returned combinationally for imem_addr
//  redirect_valid  in   1        branch taken / PC load request, single cycle
//  redirect_pc     in   ADDR_W   target byte address; bits [1:0] forced to 0
//  out_valid       out  1        queue head valid (count != 0)
//  out_ready       in   1        decode accepts head this cycle
//  out_instr       out  INSTR_W  head instruction
//  out_pc          out  ADDR_W   head PC
//  done            out  1        1 in IDLE (program space exhausted, queue empty)
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, count=0, rd/wr ptrs=0, state=RUN, done=0.
//    Queue storage cleared, so out_instr=0 and out_pc=0.
//  pop  = out_valid & out_ready.
//  push = state==RUN & fetch_en & !redirect_valid & pc<END_PC & (count<DEPTH | pop).
//  push: enqueue {pc, imem_rd}; pc <= pc + 4, modulo 2^ADDR_W.
//  Simultaneous push+pop at count==DEPTH is legal; count is unchanged.
//  Head outputs are driven from registered storage, with no combinational path from imem_rd.
//  Latency: instruction at pc is visible on out_* the cycle after its push.
//    First out_valid is in cycle 1 after reset release.
//  Redirect has priority over push and pop in every state:
//    - queue flushed (count=0, ptrs=0); pop ignored, head NOT consumed.
//    - pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
//    - next state = RUN if target < END_PC, else DRAIN.
//    - new-target instruction valid 2 cycles after redirect_valid.
//  FSM states (fetch_state_t):
//    RUN:   push per rule; pc>=END_PC -> DRAIN (no push in that cycle).
//    DRAIN: no push; count==0, or count==1 & pop -> IDLE.
//    IDLE:  no push; done=1; only redirect leaves IDLE.
//  fetch_en=0 in RUN: pc and state hold; queue drains via pop.
//  Overflow and underflow are impossible by construction.
//  out_ready while out_valid=0 has no effect.
//  Reset mid-operation: queue contents discarded, fetch restarts at RESET_PC.
//  Pointer width is $clog2(DEPTH); count width is $clog2(DEPTH)+1.
// STRUCTURE
//  Package fetch_pkg:
//    - fetch_state_t enum {RUN, DRAIN, IDLE}.
//    - fetch_entry_t struct {pc[ADDR_W], instr[INSTR_W]}.
//    - PC_STEP = 4.
//  Sub-module fetch_queue: parameterised synchronous FIFO of fetch_entry_t.
//    - push/pop/flush inputs; head/count/full/empty outputs.
//    - flush overrides push/pop.
//  Top level holds the pc register, FSM, push/pop logic and imem_addr.
// TESTING
//  Reset, fetch_en=1, out_ready=1, ROM word i=i:
//    -> out_pc 0,4,8,... back-to-back from cycle 1; out_instr matches word pc>>2.
//  out_ready=0 for 5 cycles after reset:
//    -> count saturates at 2; pc holds at 8; heads pc=0 then pc=4 delivered in order once ready=1.
//  redirect_valid with redirect_pc=0x1F (count=2):
//    -> next cycle out_valid=0, imem_addr=0x1C; cycle after, out_pc=0x1C.
//  Run to end (END_PC=404):
//    -> last pushed pc=400; DRAIN, then IDLE with done=1 after the final pop; imem_addr stays 404.
//  In IDLE, redirect_pc=8:
//    -> done=0 next cycle, state RUN, out_pc=8 two cycles after the redirect.
//  Assert reset while count=2:
//    -> immediately out_valid=0, imem_addr=RESET_PC; no stale entry delivered after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   localparam int unsigned ADDR_W  = 18;
   localparam int unsigned INSTR_W = 18;
   localparam int unsigned PC_STEP = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      IDLE  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush overrides push/pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic                         i_flush,
   input  fetch_entry_t                 i_data,
   output fetch_entry_t                 o_head,
   output logic [$clog2(DEPTH):0]       o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t       r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head comes straight from storage so nothing combinational reaches decode.
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_controller.sv
// Front-end fetch sequencer: owns the PC, fills the prefetch queue from imem and
// hands entries to decode; branch redirects flush and refetch.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned END_PC   = 404
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rd,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               done
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t        r_state;
   fetch_state_t        w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic                r_done;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [CNT_W-1:0]    w_count;
   logic [ADDR_W-1:0]   w_target;
   logic                w_pc_in_range;
   logic                w_target_in_range;
   fetch_entry_t        w_entry;
   fetch_entry_t        w_head;

   assign w_target          = redirect_pc & ~ADDR_W'(3);
   assign w_pc_in_range     = (r_pc < ADDR_W'(END_PC));
   assign w_target_in_range = (w_target < ADDR_W'(END_PC));
   assign w_entry           = '{pc: r_pc, instr: imem_rd};

   // Redirect wins over everything: the head is not consumed in that cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_push      = 1'b0;
      w_pop       = !w_empty && out_ready && !redirect_valid;
      if (redirect_valid) begin
         w_pc_nxt    = w_target;
         w_state_nxt = w_target_in_range ? RUN : DRAIN;
      end else begin
         case (r_state)
            RUN: begin
               if (!w_pc_in_range) begin
                  w_state_nxt = DRAIN;
               end else if (fetch_en && (!w_full || w_pop)) begin
                  w_push   = 1'b1;
                  w_pc_nxt = r_pc + ADDR_W'(PC_STEP);
               end
            end
            DRAIN: begin
               if (w_empty || (w_count == CNT_W'(1) && w_pop)) begin
                  w_state_nxt = IDLE;
               end
            end
            IDLE:    w_state_nxt = IDLE;
            default: w_state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
         r_pc    <= ADDR_W'(RESET_PC);
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_done  <= (w_state_nxt == IDLE);
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  (w_entry),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign imem_addr = r_pc;
   assign out_valid = !w_empty;
   assign out_pc    = w_head.pc;
   assign out_instr = w_head.instr;
   assign done      = r_done;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller against a queue-based reference model.
module tb_fetch_controller;

   localparam int unsigned DEPTH    = 2;
   localparam int unsigned RESET_PC = 0;
   localparam int unsigned END_PC   = 404;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [17:0] imem_addr;
   logic [17:0] imem_rd;
   logic        redirect_valid;
   logic [17:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [17:0] out_instr;
   logic [17:0] out_pc;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int q_pc[$];
   int q_ins[$];
   int m_pc;
   bit m_exhausted;
   bit m_done;

   always #5 clk = ~clk;

   function automatic logic [17:0] rom(input logic [17:0] a);
      logic [15:0] w;
      w = a[17:2];
      return 18'(32'(w) * 32'd3 + 32'd7);
   endfunction

   assign imem_rd = rom(imem_addr);

   fetch_controller #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .END_PC   (END_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rd        (imem_rd),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .done           (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q_pc.delete();
      q_ins.delete();
      m_pc        = int'(RESET_PC);
      m_exhausted = 1'b0;
      m_done      = 1'b0;
   endfunction

   // One clock of the behavioural rules: redirect > pop/push; stop at END_PC.
   function automatic void model_step(input bit en, input bit rdy, input bit rv, input logic [17:0] rpc);
      bit pop;
      bit push;
      bit was_exh;
      int old_pc;
      was_exh = m_exhausted;
      old_pc  = m_pc;
      pop  = (q_pc.size() != 0) && rdy && !rv;
      push = !m_exhausted && en && !rv && (m_pc < int'(END_PC)) &&
             ((q_pc.size() < int'(DEPTH)) || pop);
      if (rv) begin
         q_pc.delete();
         q_ins.delete();
         m_pc        = int'(rpc) & 'h3FFFC;
         m_exhausted = (m_pc >= int'(END_PC));
         m_done      = 1'b0;
      end else begin
         if (pop) begin
            void'(q_pc.pop_front());
            void'(q_ins.pop_front());
         end
         if (push) begin
            q_pc.push_back(old_pc);
            q_ins.push_back(int'(rom(18'(old_pc))));
            m_pc = (m_pc + 4) & 'h3FFFF;
         end
         if (!was_exh) begin
            if (old_pc >= int'(END_PC)) m_exhausted = 1'b1;
            m_done = 1'b0;
         end else begin
            m_done = (q_pc.size() == 0);
         end
      end
   endfunction

   task automatic compare_outputs();
      check_eq("out_valid", 32'(out_valid), 32'(q_pc.size() != 0));
      check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
      check_eq("done", 32'(done), 32'(m_done));
      if (q_pc.size() != 0) begin
         check_eq("out_pc", 32'(out_pc), 32'(q_pc[0]));
         check_eq("out_instr", 32'(out_instr), 32'(q_ins[0]));
      end
   endtask

   task automatic cycle(input bit en, input bit rdy, input bit rv, input logic [17:0] rpc);
      fetch_en       = en;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      model_step(en, rdy, rv, rpc);
      @(negedge clk);
      compare_outputs();
   endtask

   // Asserts reset right now (asynchronously), checks, then releases on a falling edge.
   task automatic do_reset();
      reset          = 1'b1;
      fetch_en       = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      model_reset();
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_addr", 32'(imem_addr), 32'(RESET_PC));
      check_eq("rst_pc", 32'(out_pc), 32'd0);
      check_eq("rst_instr", 32'(out_instr), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int guard;
      logic [17:0] tgt;

      // Back-to-back streaming from reset
      do_reset();
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, '0);

      // Decode stalled: queue saturates, pc holds at 8
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, '0);
      check_eq("hold_addr", 32'(imem_addr), 32'd8);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0);

      // Redirect to unaligned target with a full queue
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b1, 18'h1F);
      check_eq("redir_addr", 32'(imem_addr), 32'h1C);
      check_eq("redir_valid", 32'(out_valid), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, '0);
      check_eq("redir_head", 32'(out_pc), 32'h1C);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);

      // Run to end of program space
      guard = 0;
      while (!m_done && guard < 300) begin
         cycle(1'b1, 1'b1, 1'b0, '0);
         guard++;
      end
      check_eq("end_done", 32'(done), 32'd1);
      check_eq("end_addr", 32'(imem_addr), 32'd404);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);

      // Leave IDLE via redirect
      cycle(1'b1, 1'b1, 1'b1, 18'd8);
      check_eq("idle_exit_done", 32'(done), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, '0);
      check_eq("idle_exit_pc", 32'(out_pc), 32'd8);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);

      // Reset while the queue is full; no stale entry afterwards
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, '0);
      #2;
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         bit en;
         bit rdy;
         bit rv;
         en  = ($urandom_range(0, 99) < 85);
         rdy = ($urandom_range(0, 99) < 70);
         rv  = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 9) == 0) tgt = 18'($urandom);
         else                           tgt = 18'($urandom_range(300, 420));
         if ($urandom_range(0, 3) == 0) tgt = 18'($urandom_range(0, 60));
         cycle(en, rdy, rv, tgt);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
